// File: rtl/fir_pkg.sv
// Shared types and defaults for the adder-tree FIR and its coefficient controller.
package fir_pkg;

    localparam int FIR_WIDTH = 16;
    localparam int FIR_ORDER = 53;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        PEND_SWAP
    } state_t;

    // Bank 0 comes out of reset as a pass-through filter (tap0 = 1); bank 1 is zero.
    function automatic logic reset_tap_is_one(input int bank, input int tap);
        return (bank == 0) && (tap == 0);
    endfunction

endpackage

// File: rtl/fir_coeff_bank.sv
// Double-buffered coefficient storage: two ORDER x WIDTH banks, one write port,
// and a zero-latency read mux selecting the active bank.
module fir_coeff_bank
    import fir_pkg::*;
#(
    parameter int WIDTH = FIR_WIDTH,
    parameter int ORDER = FIR_ORDER,
    parameter int IDX_W = $clog2(ORDER)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   we_i,
    input  logic                   wbank_i,
    input  logic [IDX_W-1:0]       widx_i,
    input  logic [WIDTH-1:0]       wdata_i,
    input  logic                   bank_sel_i,
    output logic [ORDER*WIDTH-1:0] coeff_flat_o
);

    logic [1:0][ORDER-1:0][WIDTH-1:0] bank_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int b = 0; b < 2; b++) begin
                for (int k = 0; k < ORDER; k++) begin
                    bank_q[b][k] <= WIDTH'(reset_tap_is_one(b, k));
                end
            end
        end else if (we_i) begin
            bank_q[wbank_i][widx_i] <= wdata_i;
        end
    end

    // Packed layout puts tap k at [k*WIDTH +: WIDTH] directly.
    assign coeff_flat_o = bank_q[bank_sel_i];

endmodule

// File: rtl/fir_coeff_ctrl.sv
// Run-time coefficient loader: streams a tap set into the shadow bank, swaps
// banks on a sample boundary, and reports delay-line fill after reset.
module fir_coeff_ctrl
    import fir_pkg::*;
#(
    parameter int WIDTH = FIR_WIDTH,
    parameter int ORDER = FIR_ORDER
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   cfg_start,
    input  logic                   cfg_valid,
    output logic                   cfg_ready,
    input  logic [WIDTH-1:0]       cfg_data,
    input  logic                   cfg_last,
    input  logic                   sample_strobe,
    output logic [ORDER*WIDTH-1:0] coeff_flat,
    output logic                   bank_sel,
    output logic                   load_busy,
    output logic                   load_err,
    output logic                   swap_done,
    output logic                   y_valid
);

    localparam int IDX_W  = $clog2(ORDER);
    localparam int FILL_W = $clog2(ORDER + 1);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(ORDER - 1);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(ORDER);

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   wr_idx_q, wr_idx_d;
    logic [FILL_W-1:0]  fill_q, fill_d;
    logic               bank_sel_q, bank_sel_d;
    logic               err_q, err_d;
    logic               swap_q, swap_d;
    logic               y_valid_q;
    logic               we;

    always_comb begin
        state_d    = state_q;
        wr_idx_d   = wr_idx_q;
        bank_sel_d = bank_sel_q;
        err_d      = 1'b0;
        swap_d     = 1'b0;
        we         = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (cfg_start) begin
                    state_d  = LOAD;
                    wr_idx_d = '0;
                end
            end
            LOAD: begin
                if (cfg_valid) begin
                    we       = 1'b1;
                    wr_idx_d = wr_idx_q + 1'b1;
                    if (cfg_last) begin
                        if (wr_idx_q == LAST_IDX) begin
                            state_d = PEND_SWAP;
                        end else begin
                            state_d = IDLE;
                            err_d   = 1'b1;
                        end
                    end else if (wr_idx_q == LAST_IDX) begin
                        // Set would overrun ORDER taps; abandon it.
                        state_d = IDLE;
                        err_d   = 1'b1;
                    end
                end
            end
            PEND_SWAP: begin
                if (sample_strobe) begin
                    bank_sel_d = ~bank_sel_q;
                    swap_d     = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign fill_d = (sample_strobe && fill_q != FILL_MAX) ? fill_q + 1'b1 : fill_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            wr_idx_q   <= '0;
            fill_q     <= '0;
            bank_sel_q <= 1'b0;
            err_q      <= 1'b0;
            swap_q     <= 1'b0;
            y_valid_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_idx_q   <= wr_idx_d;
            fill_q     <= fill_d;
            bank_sel_q <= bank_sel_d;
            err_q      <= err_d;
            swap_q     <= swap_d;
            y_valid_q  <= (fill_d == FILL_MAX);
        end
    end

    assign cfg_ready = (state_q == LOAD);
    assign load_busy = (state_q != IDLE);
    assign load_err  = err_q;
    assign swap_done = swap_q;
    assign bank_sel  = bank_sel_q;
    assign y_valid   = y_valid_q;

    fir_coeff_bank #(
        .WIDTH (WIDTH),
        .ORDER (ORDER),
        .IDX_W (IDX_W)
    ) u_bank (
        .clk          (clk),
        .reset        (reset),
        .we_i         (we),
        .wbank_i      (~bank_sel_q),
        .widx_i       (wr_idx_q),
        .wdata_i      (cfg_data),
        .bank_sel_i   (bank_sel_q),
        .coeff_flat_o (coeff_flat)
    );

endmodule

// File: tb/tb_fir_coeff_ctrl.sv
// Scoreboard bench for fir_coeff_ctrl: randomized tap-set loads against a tap-list model.
module tb_fir_coeff_ctrl;
    localparam int WIDTH = 16;
    localparam int ORDER = 4;

    logic                   clk = 1'b0;
    logic                   reset = 1'b1;
    logic                   cfg_start = 1'b0, cfg_valid = 1'b0, cfg_last = 1'b0;
    logic [WIDTH-1:0]       cfg_data = '0;
    logic                   sample_strobe = 1'b0;
    logic                   cfg_ready, bank_sel, load_busy, load_err, swap_done, y_valid;
    logic [ORDER*WIDTH-1:0] coeff_flat;

    always #5 clk = ~clk;

    fir_coeff_ctrl #(.WIDTH(WIDTH), .ORDER(ORDER)) dut (
        .clk(clk), .reset(reset), .cfg_start(cfg_start), .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready), .cfg_data(cfg_data), .cfg_last(cfg_last),
        .sample_strobe(sample_strobe), .coeff_flat(coeff_flat), .bank_sel(bank_sel),
        .load_busy(load_busy), .load_err(load_err), .swap_done(swap_done), .y_valid(y_valid)
    );

    typedef struct {
        bit                     is_swap;
        bit                     sel;
        logic [ORDER*WIDTH-1:0] taps;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    int unsigned model_taps[ORDER];
    bit          model_sel;
    int          model_fill = 0;

    task automatic check(input string name, input logic [ORDER*WIDTH-1:0] got,
                         input logic [ORDER*WIDTH-1:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    function automatic logic [ORDER*WIDTH-1:0] pack_taps();
        logic [ORDER*WIDTH-1:0] r;
        for (int k = 0; k < ORDER; k++) r[k*WIDTH +: WIDTH] = WIDTH'(model_taps[k]);
        return r;
    endfunction

    function automatic void model_reset();
        for (int k = 0; k < ORDER; k++) model_taps[k] = (k == 0) ? 1 : 0;
        model_sel = 1'b0;
    endfunction

    // One clock: the model sees the inputs that were present on the edge.
    task automatic step();
        @(posedge clk);
        if (reset) model_fill = 0;
        else if (sample_strobe && model_fill < ORDER) model_fill++;
        #1;
    endtask

    // Monitor: every swap_done / load_err pulse must match the next expected event.
    always @(negedge clk) begin
        if (!reset && (swap_done || load_err)) begin
            if (sb.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_event: swap_done=%0b load_err=%0b, none expected",
                         swap_done, load_err);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("event_kind_swap", swap_done, e.is_swap);
                check("event_kind_err", load_err, !e.is_swap);
                check("event_bank_sel", bank_sel, e.sel);
                check("event_coeff", coeff_flat, e.taps);
                if (e.is_swap) check("busy_after_swap", load_busy, 0);
            end
        end
    end

    // nbeats offered; abort_after < nbeats asserts reset instead of that beat.
    task automatic do_load(input int nbeats, input bit last_final, input bit gaps,
                           input bit start_mid, input int abort_after);
        int unsigned vals[$];
        bit          ok = 1'b0;
        bit          done = 1'b0;
        cfg_start = 1'b1;
        step();
        cfg_start = 1'b0;
        for (int i = 0; i < nbeats; i++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    cfg_valid     = 1'b0;
                    cfg_start     = start_mid & 1'($urandom_range(0, 1));
                    sample_strobe = 1'($urandom_range(0, 1));
                    step();
                end
                cfg_start     = 1'b0;
                sample_strobe = 1'b0;
            end
            if (i == abort_after) begin
                cfg_valid = 1'b0;
                reset     = 1'b1;
                step();
                reset = 1'b0;
                model_reset();
                @(negedge clk);
                check("abort_coeff", coeff_flat, pack_taps());
                check("abort_bank_sel", bank_sel, 0);
                check("abort_busy", load_busy, 0);
                check("abort_ready", cfg_ready, 0);
                check("abort_y_valid", y_valid, 0);
                repeat (3) step();
                return;
            end
            cfg_valid = 1'b1;
            cfg_data  = WIDTH'($urandom);
            cfg_last  = last_final && (i == nbeats - 1);
            @(negedge clk);
            check("cfg_ready_beat", cfg_ready, !done);
            if (!done) begin
                check("busy_in_load", load_busy, 1);
                vals.push_back(int'(cfg_data));
                if (cfg_last && vals.size() == ORDER) begin
                    ok = 1'b1;
                    done = 1'b1;
                end else if (cfg_last || vals.size() == ORDER) begin
                    sb.push_back('{is_swap: 1'b0, sel: model_sel, taps: pack_taps()});
                    done = 1'b1;
                end
            end
            step();
        end
        cfg_valid = 1'b0;
        cfg_last  = 1'b0;
        if (ok) begin
            repeat ($urandom_range(0, 3)) begin
                cfg_start = start_mid & 1'($urandom_range(0, 1));
                @(negedge clk);
                check("busy_pend", load_busy, 1);
                check("ready_pend", cfg_ready, 0);
                step();
            end
            // cfg_start on the swap edge must not start a new load.
            cfg_start     = start_mid;
            sample_strobe = 1'b1;
            for (int k = 0; k < ORDER; k++) model_taps[k] = vals[k];
            model_sel = !model_sel;
            sb.push_back('{is_swap: 1'b1, sel: model_sel, taps: pack_taps()});
            step();
            cfg_start     = 1'b0;
            sample_strobe = 1'b0;
            @(negedge clk);
            check("ready_after_swap", cfg_ready, 0);
            check("coeff_after_swap", coeff_flat, pack_taps());
        end
        repeat (3) step();
        @(negedge clk);
        check("idle_coeff", coeff_flat, pack_taps());
        check("idle_bank_sel", bank_sel, model_sel);
        check("idle_busy", load_busy, 0);
    endtask

    initial begin
        model_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        @(negedge clk);
        check("rst_coeff", coeff_flat, pack_taps());
        check("rst_bank_sel", bank_sel, 0);
        check("rst_ready", cfg_ready, 0);
        check("rst_busy", load_busy, 0);
        check("rst_err", load_err, 0);
        check("rst_swap", swap_done, 0);
        check("rst_y_valid", y_valid, 0);

        for (int s = 0; s < ORDER + 2; s++) begin
            sample_strobe = 1'b1;
            step();
            sample_strobe = 1'b0;
            @(negedge clk);
            check("y_valid_fill", y_valid, model_fill >= ORDER);
            step();
        end

        do_load(ORDER, 1, 0, 0, -1);           // clean load
        do_load(ORDER - 1, 1, 0, 0, -1);       // short set
        do_load(ORDER + 1, 0, 0, 0, -1);       // long set
        do_load(ORDER, 1, 1, 1, -1);           // gaps + cfg_start mid-load
        do_load(ORDER, 1, 0, 0, -1);           // leaves bank_sel=1 before abort
        do_load(ORDER, 1, 0, 0, 2);            // reset mid-load
        do_load(ORDER, 1, 0, 0, -1);           // full load after reset
        @(negedge clk);
        check("fill_after_reset", y_valid, model_fill >= ORDER);

        for (int it = 0; it < 25; it++) begin
            case ($urandom_range(0, 3))
                0, 1: do_load(ORDER, 1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), -1);
                2:    do_load($urandom_range(1, ORDER - 1), 1, 1'($urandom_range(0, 1)), 0, -1);
                default: do_load(ORDER + 1, 0, 1'($urandom_range(0, 1)), 0, -1);
            endcase
        end

        repeat (5) step();
        @(negedge clk);
        check("scoreboard_drained", sb.size(), 0);
        check("final_y_valid", y_valid, model_fill >= ORDER);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, %0d/%0d so far", n_pass, n_checks);
        $fatal(1);
    end
endmodule
